// File: rtl/wb_stage_gen.sv
// Writeback stage: holds one instruction, waits for load data, writes the GR file,
// drives CSR access, turns exceptions/ertn into flushes and counts retirements.
module wb_stage_gen #(
  parameter int                     XLEN      = 32,
  parameter int                     RF_AW     = 5,
  parameter int                     NUM_EXC   = 6,
  parameter logic [6*NUM_EXC-1:0]   ECODE_TAB = {6'h0D, 6'h0C, 6'h0B, 6'h09, 6'h08, 6'h00},
  parameter int                     CNT_W     = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               in_gr_we,
  input  logic [RF_AW-1:0]   in_dest,
  input  logic [XLEN-1:0]    in_result,
  input  logic               in_is_load,
  input  logic               in_csr_re,
  input  logic               in_csr_we,
  input  logic [13:0]        in_csr_num,
  input  logic [XLEN-1:0]    in_csr_wmask,
  input  logic [XLEN-1:0]    in_csr_wvalue,
  input  logic [NUM_EXC-1:0] in_exc_vec,
  input  logic               in_ertn,
  input  logic [XLEN-1:0]    in_vaddr,
  input  logic               ld_rvalid,
  input  logic [XLEN-1:0]    ld_rdata,
  input  logic [XLEN-1:0]    csr_rvalue,
  output logic               csr_re,
  output logic               csr_we,
  output logic [13:0]        csr_num,
  output logic [XLEN-1:0]    csr_wmask,
  output logic [XLEN-1:0]    csr_wvalue,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic [RF_AW-1:0]   fwd_dest,
  output logic [XLEN-1:0]    fwd_value,
  output logic               fwd_stall,
  output logic               exc_flush,
  output logic [5:0]         exc_ecode,
  output logic [XLEN-1:0]    exc_pc,
  output logic [XLEN-1:0]    exc_vaddr,
  output logic               ertn_flush,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [XLEN-1:0]    debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [RF_AW-1:0]   debug_wb_rf_wnum,
  output logic [XLEN-1:0]    debug_wb_rf_wdata
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WAIT_LD = 2'd1,
    S_READY   = 2'd2
  } state_t;

  state_t             state;
  logic [XLEN-1:0]    pc_r, result_r, csr_wmask_r, csr_wvalue_r, vaddr_r, ld_buf;
  logic               gr_we_r, is_load_r, csr_re_r, csr_we_r, ertn_r;
  logic [RF_AW-1:0]   dest_r;
  logic [13:0]        csr_num_r;
  logic [NUM_EXC-1:0] exc_vec_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               valid, has_exc, ld_hit, go, flush, capture, csr_active, exc_live;
  logic [XLEN-1:0]    wdata;
  logic [5:0]         ecode_sel;

  assign valid      = (state != S_EMPTY);
  assign has_exc    = |exc_vec_r;
  // Load data only counts while a load is actually waiting for it.
  assign ld_hit     = ld_rvalid & (state == S_WAIT_LD);
  assign go         = valid & ((state == S_READY) | ld_hit);
  assign in_ready   = ~valid | go;
  assign flush      = go & (has_exc | ertn_r);
  assign capture    = in_valid & in_ready & ~flush;
  assign csr_active = valid & ~has_exc;
  assign exc_live   = valid & has_exc;

  assign csr_re     = csr_active & csr_re_r;
  assign csr_we     = go & ~has_exc & csr_we_r;
  assign csr_num    = csr_active ? csr_num_r    : '0;
  assign csr_wmask  = csr_active ? csr_wmask_r  : '0;
  assign csr_wvalue = csr_active ? csr_wvalue_r : '0;

  assign wdata = csr_re    ? csr_rvalue :
                 is_load_r ? (ld_hit ? ld_rdata : ld_buf) : result_r;

  assign rf_we     = go & gr_we_r & ~has_exc;
  assign rf_waddr  = dest_r;
  assign rf_wdata  = wdata;
  assign fwd_dest  = (valid & gr_we_r & ~has_exc) ? dest_r : '0;
  assign fwd_value = wdata;
  assign fwd_stall = (state == S_WAIT_LD) & ~ld_rvalid;

  assign exc_flush  = go & has_exc;
  assign ertn_flush = go & ertn_r & ~has_exc;
  assign exc_ecode  = exc_live ? ecode_sel : '0;
  assign exc_pc     = exc_live ? pc_r      : '0;
  assign exc_vaddr  = exc_live ? vaddr_r   : '0;
  assign retire_cnt = cnt_r;

  assign debug_wb_pc       = pc_r;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Bit 0 is highest priority: scan downwards so the lowest set index wins.
  always_comb begin
    // NOTE: default first so every path assigns ecode_sel and no latch is inferred.
    ecode_sel = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_vec_r[i]) ecode_sel = ECODE_TAB[6*i +: 6];
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset clears everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_EMPTY;
      pc_r         <= '0;
      gr_we_r      <= 1'b0;
      dest_r       <= '0;
      result_r     <= '0;
      is_load_r    <= 1'b0;
      csr_re_r     <= 1'b0;
      csr_we_r     <= 1'b0;
      csr_num_r    <= '0;
      csr_wmask_r  <= '0;
      csr_wvalue_r <= '0;
      exc_vec_r    <= '0;
      ertn_r       <= 1'b0;
      vaddr_r      <= '0;
      ld_buf       <= '0;
      cnt_r        <= '0;
    end else begin
      if (capture) begin
        // A load with an exception never waits for its data.
        state        <= (in_is_load && !(|in_exc_vec)) ? S_WAIT_LD : S_READY;
        pc_r         <= in_pc;
        gr_we_r      <= in_gr_we;
        dest_r       <= in_dest;
        result_r     <= in_result;
        is_load_r    <= in_is_load;
        csr_re_r     <= in_csr_re;
        csr_we_r     <= in_csr_we;
        csr_num_r    <= in_csr_num;
        csr_wmask_r  <= in_csr_wmask;
        csr_wvalue_r <= in_csr_wvalue;
        exc_vec_r    <= in_exc_vec;
        ertn_r       <= in_ertn;
        vaddr_r      <= in_vaddr;
      end else if (in_ready) begin
        state <= S_EMPTY;
      end
      if (ld_hit) ld_buf <= ld_rdata;
      if (go && !has_exc) cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage_gen.sv
// Scoreboard bench for wb_stage_gen: directed scenarios plus random traffic checked
// against an instruction-level model of what each retirement must look like.
module tb_wb_stage_gen;
  localparam int XLEN = 32, RF_AW = 5, NUM_EXC = 6, CNT_W = 4;
  localparam logic [5:0] ECODES [6] = '{6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D};

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic               in_valid, in_ready, in_gr_we, in_is_load, in_csr_re, in_csr_we, in_ertn;
  logic [XLEN-1:0]    in_pc, in_result, in_csr_wmask, in_csr_wvalue, in_vaddr;
  logic [RF_AW-1:0]   in_dest;
  logic [13:0]        in_csr_num;
  logic [NUM_EXC-1:0] in_exc_vec;
  logic               ld_rvalid;
  logic [XLEN-1:0]    ld_rdata, csr_rvalue;
  logic               csr_re, csr_we, rf_we, fwd_stall, exc_flush, ertn_flush;
  logic [13:0]        csr_num;
  logic [XLEN-1:0]    csr_wmask, csr_wvalue, rf_wdata, fwd_value, exc_pc, exc_vaddr;
  logic [XLEN-1:0]    debug_wb_pc, debug_wb_rf_wdata;
  logic [RF_AW-1:0]   rf_waddr, fwd_dest, debug_wb_rf_wnum;
  logic [5:0]         exc_ecode;
  logic [CNT_W-1:0]   retire_cnt;
  logic [3:0]         debug_wb_rf_we;

  wb_stage_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_gr_we(in_gr_we), .in_dest(in_dest), .in_result(in_result), .in_is_load(in_is_load),
    .in_csr_re(in_csr_re), .in_csr_we(in_csr_we), .in_csr_num(in_csr_num),
    .in_csr_wmask(in_csr_wmask), .in_csr_wvalue(in_csr_wvalue), .in_exc_vec(in_exc_vec),
    .in_ertn(in_ertn), .in_vaddr(in_vaddr), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .csr_rvalue(csr_rvalue), .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_dest(fwd_dest), .fwd_value(fwd_value), .fwd_stall(fwd_stall),
    .exc_flush(exc_flush), .exc_ecode(exc_ecode), .exc_pc(exc_pc), .exc_vaddr(exc_vaddr),
    .ertn_flush(ertn_flush), .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Behavioural CSR file: CSR 5 reads 0xABCD, others a number-derived pattern.
  function automatic logic [XLEN-1:0] csr_model(input logic [13:0] num);
    return (num == 14'h5) ? 32'h0000_ABCD : ({18'h0, num} ^ 32'h5A5A_0000);
  endfunction
  assign csr_rvalue = csr_model(csr_num);

  typedef struct {
    logic [31:0] pc, result, ld_data, wmask, wvalue, vaddr;
    logic        gr_we, is_load, csr_re, csr_we, ertn;
    logic [4:0]  dest;
    logic [13:0] csr_num;
    logic [5:0]  exc_vec;
  } instr_t;

  typedef struct {
    logic        rf_we, exc_flush, ertn_flush, csr_we;
    logic [4:0]  waddr;
    logic [31:0] wdata, pc, wmask, wvalue, vaddr;
    logic [5:0]  ecode;
    logic [13:0] csr_num;
    logic [3:0]  cnt;
  } exp_t;

  int checks = 0, failures = 0;
  exp_t        sb_q[$];
  logic [31:0] ld_q[$];
  int unsigned model_retired = 0;
  bit resp_en = 1'b1, spur_en = 1'b0, waiting = 1'b0;
  int ld_delay = -1;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [319:0] all_outs();
    return {csr_re, csr_we, csr_num, csr_wmask, csr_wvalue, rf_we, rf_waddr, rf_wdata,
            fwd_dest, fwd_value, fwd_stall, exc_flush, exc_ecode, exc_pc, exc_vaddr,
            ertn_flush, retire_cnt, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum,
            debug_wb_rf_wdata};
  endfunction

  function automatic logic [5:0] ecode_of(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return ECODES[i];
    return 6'h00;
  endfunction

  // Reference model: what retiring this instruction must look like.
  task automatic predict(input instr_t t);
    exp_t e;
    bit exc = |t.exc_vec;
    e.rf_we      = t.gr_we && !exc;
    e.waddr      = t.dest;
    e.wdata      = t.is_load ? t.ld_data : (t.csr_re ? csr_model(t.csr_num) : t.result);
    e.pc         = t.pc;
    e.exc_flush  = exc;
    e.ertn_flush = t.ertn && !exc;
    e.ecode      = ecode_of(t.exc_vec);
    e.vaddr      = t.vaddr;
    e.csr_we     = t.csr_we && !exc;
    e.csr_num    = t.csr_num;
    e.wmask      = t.wmask;
    e.wvalue     = t.wvalue;
    e.cnt        = 4'(model_retired);
    if (!exc) model_retired++;
    if (exc || t.gr_we || t.csr_we || t.ertn) sb_q.push_back(e);
    if (t.is_load && !exc) ld_q.push_back(t.ld_data);
  endtask

  task automatic drive(input instr_t t);
    in_valid = 1'b1;       in_pc = t.pc;           in_gr_we = t.gr_we;
    in_dest = t.dest;      in_result = t.result;   in_is_load = t.is_load;
    in_csr_re = t.csr_re;  in_csr_we = t.csr_we;   in_csr_num = t.csr_num;
    in_csr_wmask = t.wmask; in_csr_wvalue = t.wvalue;
    in_exc_vec = t.exc_vec; in_ertn = t.ertn;      in_vaddr = t.vaddr;
  endtask

  // Called and returns at posedge+1; an offer made during a flush cycle is dropped, so re-offer.
  task automatic issue(input instr_t t);
    int n = 0;
    drive(t);
    forever begin
      @(negedge clk);
      if (in_ready && !exc_flush && !ertn_flush) break;
      if (++n > 50) begin
        checks++; failures++;
        $display("FAIL issue_timeout: got in_ready stuck low expected accept within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    predict(t);
    #1 in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drain", 320'(sb_q.size()), 320'd0);
    step();
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] dest,
                                input logic [31:0] result);
    instr_t t = '{default: 0};
    t.pc = pc; t.dest = dest; t.result = result; t.gr_we = 1'b1;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t = mk($urandom & 32'hFFFF_FFFC, 5'($urandom), $urandom);
    int k = int'($urandom_range(0, 9));
    t.gr_we = ($urandom_range(0, 3) != 0);
    t.vaddr = $urandom;
    if (k >= 4 && k <= 6) begin
      t.is_load = 1'b1; t.ld_data = $urandom;
    end else if (k == 7) begin
      t.csr_re = 1'b1; t.csr_num = 14'($urandom);
    end else if (k == 8) begin
      t.csr_we = 1'b1; t.csr_re = 1'($urandom); t.csr_num = 14'($urandom);
      t.wmask = $urandom; t.wvalue = $urandom;
    end else if (k == 9) begin
      t.ertn = 1'b1; t.gr_we = 1'b0;
    end
    if ($urandom_range(0, 4) == 0) t.exc_vec = 6'($urandom_range(1, 63));
    return t;
  endfunction

  // Memory responder: answers a waiting load after a delay, sometimes pulses stray data.
  initial begin
    int cnt = 0;
    ld_rvalid = 1'b0;
    ld_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        ld_rvalid = 1'b0;
        #1;
        if (fwd_stall) begin
          if (!waiting) begin
            waiting = 1'b1;
            cnt = (ld_delay >= 0) ? ld_delay : int'($urandom_range(0, 3));
          end
          if (cnt == 0) begin
            waiting = 1'b0;
            ld_rvalid = 1'b1;
            if (ld_q.size() != 0) ld_rdata = ld_q.pop_front();
            else ld_rdata = 32'hBAD0_BAD0;
          end else cnt--;
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
          ld_rvalid = 1'b1;
          ld_rdata  = $urandom;
        end
      end
    end
  end

  // Monitor: every visible retirement pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_we || exc_flush || ertn_flush || csr_we) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event: got rf_we=%0b exc=%0b ertn=%0b csr_we=%0b pc=%0h expected none",
                   rf_we, exc_flush, ertn_flush, csr_we, debug_wb_pc);
        end else begin
          e = sb_q.pop_front();
          check("rf_write", {rf_we, rf_we ? {rf_waddr, rf_wdata} : 37'h0},
                            {e.rf_we, e.rf_we ? {e.waddr, e.wdata} : 37'h0});
          check("debug", {debug_wb_rf_we, rf_we ? {debug_wb_rf_wnum, debug_wb_rf_wdata} : 37'h0, debug_wb_pc},
                         {{4{e.rf_we}}, e.rf_we ? {e.waddr, e.wdata} : 37'h0, e.pc});
          check("forward", {fwd_dest, rf_we ? fwd_value : 32'h0},
                           {e.rf_we ? e.waddr : 5'h0, e.rf_we ? e.wdata : 32'h0});
          check("flush", {exc_flush, ertn_flush, exc_flush ? {exc_ecode, exc_pc, exc_vaddr} : 70'h0},
                         {e.exc_flush, e.ertn_flush, e.exc_flush ? {e.ecode, e.pc, e.vaddr} : 70'h0});
          check("csr_write", {csr_we, csr_we ? {csr_num, csr_wmask, csr_wvalue} : 78'h0},
                             {e.csr_we, e.csr_we ? {e.csr_num, e.wmask, e.wvalue} : 78'h0});
          check("retire_cnt", 320'(retire_cnt), 320'(e.cnt));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t a, b;
    int stall;
    bit seen;
    logic [3:0] r0;

    in_valid = 1'b0;
    drive('{default: 0});
    in_valid = 1'b0;
    resetn = 1'b0;
    #12;
    check("reset_outputs", all_outs(), 320'h0);
    check("reset_in_ready", 320'(in_ready), 320'd1);
    @(posedge clk);
    #2 resetn = 1'b1;
    step();

    // ALU write to r5, counter 0 -> 1.
    issue(mk(32'h1000, 5'd5, 32'h1234));
    step();
    check("alu_retire_cnt", 320'(retire_cnt), 320'd1);

    // Load to r7 answered after three waiting cycles.
    ld_delay = 3;
    a = mk(32'h1004, 5'd7, 32'h0);
    a.is_load = 1'b1; a.ld_data = 32'hDEAD_BEEF;
    issue(a);
    stall = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rf_we) begin
        seen = 1'b1;
        check("load_pulse_no_stall", 320'(fwd_stall), 320'd0);
      end else if (fwd_stall && !in_ready) stall++;
    end
    check("load_write_seen", 320'(seen), 320'd1);
    check("load_stall_cycles", 320'(stall), 320'd3);
    ld_delay = -1;
    step();

    // ALE + syscall: ecode 0x09, no writes, the same-cycle offer is dropped.
    a = mk(32'h1008, 5'd6, 32'h55);
    a.exc_vec = 6'b001100; a.csr_we = 1'b1; a.csr_num = 14'h7; a.vaddr = 32'h0000_1001;
    issue(a);
    b = mk(32'h100C, 5'd9, 32'h99);
    drive(b);
    @(negedge clk);
    check("exc_flush_seen", {exc_flush, exc_ecode, rf_we, csr_we}, {1'b1, 6'h09, 1'b0, 1'b0});
    @(negedge clk);
    check("exc_drop_next", 320'(fwd_dest), 320'd0);
    check("exc_cnt_unchanged", 320'(retire_cnt), 320'(4'(model_retired)));
    in_valid = 1'b0;
    step();
    issue(b);

    // ertn with exception bit 0, then ertn alone.
    a = mk(32'h1010, 5'd0, 32'h0);
    a.gr_we = 1'b0; a.ertn = 1'b1; a.exc_vec = 6'b000001;
    issue(a);
    a.exc_vec = 6'b0; a.pc = 32'h1014;
    issue(a);
    step();
    step();

    // csrrd of CSR 5 into r3.
    a = mk(32'h1018, 5'd3, 32'h0);
    a.csr_re = 1'b1; a.csr_num = 14'h5;
    issue(a);
    @(negedge clk);
    check("csr_read_port", {csr_re, csr_num, rf_wdata}, {1'b1, 14'h5, 32'h0000_ABCD});
    step();

    // 17 retirements on a 4-bit counter advance it by one modulo 16.
    r0 = retire_cnt;
    for (int i = 0; i < 17; i++) issue(mk(32'h2000 + 32'(4*i), 5'(i), 32'(i * 3)));
    drain();
    check("cnt_wrap", 320'(retire_cnt), 320'(4'(r0 + 4'd1)));

    // Random traffic with stray load responses.
    spur_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(rand_instr());
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    spur_en = 1'b0;
    check("random_cnt", 320'(retire_cnt), 320'(4'(model_retired)));

    // Asynchronous reset while a load waits; a late response must be ignored.
    ld_delay = 100;
    a = mk(32'h3000, 5'd4, 32'h0);
    a.is_load = 1'b1; a.ld_data = 32'h1111_2222;
    issue(a);
    @(negedge clk);
    check("wait_before_reset", 320'(fwd_stall), 320'd1);
    resp_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 320'h0);
    check("async_reset_ready", 320'(in_ready), 320'd1);
    sb_q.delete();
    ld_q.delete();
    waiting = 1'b0;
    model_retired = 0;
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1 ld_rvalid = 1'b1; ld_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_ld_outputs", all_outs(), 320'h0);
    check("late_ld_ready", 320'(in_ready), 320'd1);
    ld_rvalid = 1'b0;
    step();
    check("late_ld_no_retire", 320'(retire_cnt), 320'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
